rf_wb_ctrl: RTL

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

---
 rtl/rf_wb_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/rf_wb_ctrl.sv
// Writeback arbiter and register scoreboard.
// Merges ALU and LSU writebacks into one registered register-file write port.
module rf_wb_ctrl #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        chk_busy1,
    output logic        chk_busy2,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [63:0] a_data,
    output logic        a_ready,
    input  logic        l_valid,
    input  logic [4:0]  l_rd,
    input  logic [63:0] l_data,
    output logic        l_ready,
    output logic        w_en,
    output logic [4:0]  w_reg,
    output logic [63:0] w_data,
    output logic [31:0] sb_busy
);

    logic        alu_turn;
    logic        tie;
    logic        xfer;
    logic [4:0]  sel_rd;
    logic [63:0] sel_data;
    logic [31:0] busy;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    assign tie = a_valid && l_valid;

    // Grant: lone requester wins; ties go by policy; nothing under reset.
    always_comb begin
        a_ready = 1'b0;
        l_ready = 1'b0;
        if (!rst) begin
            if (tie) begin
                a_ready = RR_EN ? alu_turn : 1'b1;
                l_ready = !a_ready;
            end else begin
                a_ready = a_valid;
                l_ready = l_valid;
            end
        end
    end

    assign xfer     = (a_valid && a_ready) || (l_valid && l_ready);
    assign sel_rd   = a_ready ? a_rd : l_rd;
    assign sel_data = a_ready ? a_data : l_data;

    // Tie pointer moves only on contested cycles; after reset ALU wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_turn <= 1'b1;
        end else if (tie) begin
            alu_turn <= l_ready;
        end
    end

    // Registered write port; writes to x0 are swallowed and leave reg/data alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en   <= 1'b0;
            w_reg  <= 5'd0;
            w_data <= 64'd0;
        end else begin
            w_en <= xfer && (sel_rd != 5'd0);
            if (xfer && (sel_rd != 5'd0)) begin
                w_reg  <= sel_rd;
                w_data <= sel_data;
            end
        end
    end

    // Set from issue, clear on register-file commit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && (iss_rd != 5'd0)) begin
            set_mask[iss_rd] = 1'b1;
        end
        if (w_en) begin
            clr_mask[w_reg] = 1'b1;
        end
    end

    // Scoreboard update; set overrides a same-edge clear, x0 never busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'h1;
        end
    end

    assign chk_busy1 = busy[chk_rs1];
    assign chk_busy2 = busy[chk_rs2];
    assign sb_busy   = busy;

endmodule
